// File: rtl/subcounter_pkg.sv
// Shared types and defaults for the subcounter sequencing controller.
// The subcounter command codes match what the subcounters decode; 2'b11 is never produced.
package subcounter_pkg;

    localparam int DEF_GRANULARITY = 4;
    localparam int DEF_NUM_SUB     = 4;
    localparam int DEF_NUM_REQ     = 4;

    typedef enum logic [1:0] {
        CMD_CLEAR = 2'b00,
        CMD_INC   = 2'b01,
        CMD_HOLD  = 2'b10
    } sub_cmd_t;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_INC  = 3'd2,
        ST_CLR  = 3'd3,
        ST_ACK  = 3'd4
    } state_t;

    // Index width that stays legal when a count of one would give $clog2 == 0.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps,
// returning both a one-hot grant and its binary index.
module rr_arbiter
    import subcounter_pkg::*;
#(
    parameter int N = DEF_NUM_REQ
) (
    input  logic [N-1:0]               req,
    input  logic [idx_width(N)-1:0]    ptr,
    output logic [N-1:0]               grant,
    output logic [idx_width(N)-1:0]    idx
);

    localparam int IW = idx_width(N);

    logic found;
    int   j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/subcounter_seq_ctrl.sv
// Sequencer for a chain of GRANULARITY-bit subcounters forming one wide counter;
// arbitrates requesters round-robin and ripples carry one subcounter per cycle.
module subcounter_seq_ctrl
    import subcounter_pkg::*;
#(
    parameter int GRANULARITY = DEF_GRANULARITY,
    parameter int NUM_SUB     = DEF_NUM_SUB,
    parameter int NUM_REQ     = DEF_NUM_REQ
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_op,
    output logic [NUM_REQ-1:0]             ack,
    output logic [2*NUM_SUB-1:0]           sub_cmd,
    input  logic [NUM_SUB*GRANULARITY-1:0] sub_data_in,
    output logic [NUM_SUB*GRANULARITY-1:0] count_out,
    output logic                           busy,
    output logic                           overflow,
    output state_t                         dbg_state
);

    localparam int KW = idx_width(NUM_SUB);
    localparam int RW = idx_width(NUM_REQ);
    localparam logic [KW-1:0] K_LAST = KW'(NUM_SUB - 1);
    localparam logic [RW-1:0] R_LAST = RW'(NUM_REQ - 1);

    // Handshake: a requester raises req (with req_op stable) and holds it until
    // ack pulses for one cycle; it must drop req at the edge that ends the ack cycle.
    state_t                 state;
    logic [KW-1:0]          k;
    logic [RW-1:0]          grant_idx;
    logic [RW-1:0]          rr_ptr;
    logic [NUM_REQ-1:0]     grant_oh;
    logic [NUM_REQ-1:0]     arb_grant;
    logic [RW-1:0]          arb_idx;
    logic [GRANULARITY-1:0] sub_val [NUM_SUB];
    logic                   sub_all_ones;

    for (genvar g = 0; g < NUM_SUB; g++) begin : g_split
        assign sub_val[g] = sub_data_in[g*GRANULARITY +: GRANULARITY];
    end

    // Carry looks at the pre-increment value of subcounter k only, so no stall is needed.
    assign sub_all_ones = &sub_val[k];
    assign overflow     = (state == ST_INC) && (k == K_LAST) && sub_all_ones;
    assign count_out    = sub_data_in;
    assign dbg_state    = state;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    function automatic logic [2*NUM_SUB-1:0] cmd_all(input sub_cmd_t c);
        logic [2*NUM_SUB-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_SUB; i++) v[2*i +: 2] = c;
        return v;
    endfunction

    function automatic logic [2*NUM_SUB-1:0] cmd_inc_at(input logic [KW-1:0] sel);
        logic [2*NUM_SUB-1:0] v;
        v = cmd_all(CMD_HOLD);
        for (int i = 0; i < NUM_SUB; i++) begin
            if (KW'(i) == sel) v[2*i +: 2] = CMD_INC;
        end
        return v;
    endfunction

    // Outputs are registered alongside the next-state decision so each reflects the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            k         <= '0;
            grant_idx <= '0;
            grant_oh  <= '0;
            rr_ptr    <= '0;
            ack       <= '0;
            busy      <= 1'b1;
            sub_cmd   <= cmd_all(CMD_CLEAR);
        end else begin
            ack <= '0;
            case (state)
                ST_INIT: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    sub_cmd <= cmd_all(CMD_HOLD);
                end
                ST_IDLE: begin
                    if (|req) begin
                        grant_idx <= arb_idx;
                        grant_oh  <= arb_grant;
                        busy      <= 1'b1;
                        if (req_op[arb_idx]) begin
                            state   <= ST_CLR;
                            sub_cmd <= cmd_all(CMD_CLEAR);
                        end else begin
                            state   <= ST_INC;
                            k       <= '0;
                            sub_cmd <= cmd_inc_at('0);
                        end
                    end
                end
                ST_INC: begin
                    if (sub_all_ones && (k != K_LAST)) begin
                        k       <= k + 1'b1;
                        sub_cmd <= cmd_inc_at(k + 1'b1);
                    end else begin
                        state   <= ST_ACK;
                        ack     <= grant_oh;
                        sub_cmd <= cmd_all(CMD_HOLD);
                    end
                end
                ST_CLR: begin
                    state   <= ST_ACK;
                    ack     <= grant_oh;
                    sub_cmd <= cmd_all(CMD_HOLD);
                end
                ST_ACK: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    rr_ptr <= (grant_idx == R_LAST) ? '0 : grant_idx + 1'b1;
                end
                default: begin
                    state   <= ST_INIT;
                    busy    <= 1'b1;
                    sub_cmd <= cmd_all(CMD_CLEAR);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subcounter_seq_ctrl.sv
// Directed bench for subcounter_seq_ctrl: models four 4-bit subcounters and
// checks latency, round-robin order, carry ripple, overflow and reset abort.
module tb_subcounter_seq_ctrl;
    import subcounter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  req_op;
    logic [3:0]  ack;
    logic [7:0]  sub_cmd;
    logic [15:0] sub_data_in;
    logic [15:0] count_out;
    logic        busy;
    logic        overflow;
    state_t      dbg_state;

    logic [3:0]  subs [4];
    logic        preload_en;
    logic [15:0] preload_val;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q [$];
    int          exp_cyc [$];
    int          lat;
    int          ovf_at;
    int          got;
    logic        ack_seen;

    subcounter_seq_ctrl #(.GRANULARITY(4), .NUM_SUB(4), .NUM_REQ(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_op      (req_op),
        .ack         (ack),
        .sub_cmd     (sub_cmd),
        .sub_data_in (sub_data_in),
        .count_out   (count_out),
        .busy        (busy),
        .overflow    (overflow),
        .dbg_state   (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Subcounter models: apply the command at the rising edge, 11 behaves as HOLD
    always @(posedge clk) begin
        for (int s = 0; s < 4; s++) begin
            if (preload_en) subs[s] <= preload_val[4*s +: 4];
            else if (sub_cmd[2*s +: 2] == 2'b00) subs[s] <= 4'h0;
            else if (sub_cmd[2*s +: 2] == 2'b01) subs[s] <= subs[s] + 4'h1;
        end
    end
    assign sub_data_in = {subs[3], subs[2], subs[1], subs[0]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Driver: request in an IDLE cycle (cycle 0), report ack and overflow cycles
    task automatic do_req(input int idx, input logic op, output int l, output int ov);
        l  = -1;
        ov = -1;
        @(negedge clk);
        req[idx]    = 1'b1;
        req_op[idx] = op;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (overflow) ov = c;
            if (ack[idx]) begin
                l = c;
                break;
            end
        end
        @(negedge clk);
        req[idx]    = 1'b0;
        req_op[idx] = 1'b0;
    endtask

    task automatic preload(input logic [15:0] v);
        @(negedge clk);
        preload_en  = 1'b1;
        preload_val = v;
        @(negedge clk);
        preload_en  = 1'b0;
    endtask

    task automatic watch_ack(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (|ack) ack_seen = 1'b1;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        req         = '0;
        req_op      = '0;
        preload_en  = 1'b0;
        preload_val = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_sub_cmd", 32'(sub_cmd), 32'h00);
        check("rst_busy", 32'(busy), 32'h1);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(ST_INIT));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_count", 32'(count_out), 32'h0000);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_sub_cmd", 32'(sub_cmd), 32'hAA);
        check("idle_state", 32'(dbg_state), 32'(ST_IDLE));

        // Seventeen increments from requester 0; the 16th carries once
        for (int n = 1; n <= 17; n++) begin
            do_req(0, 1'b0, lat, ovf_at);
            if (n == 1) check("inc1_lat", 32'(lat), 32'd2);
            if (n == 16) check("inc16_lat", 32'(lat), 32'd3);
            if (n == 17) check("inc17_lat", 32'(lat), 32'd2);
        end
        check("inc17_count", 32'(count_out), 32'h0011);

        // Walk up to 0x0FFF, then a three-carry increment
        for (int n = 0; n < 16'h0FFF - 16'h0011; n++) do_req(0, 1'b0, lat, ovf_at);
        check("pre_0fff_count", 32'(count_out), 32'h0FFF);
        do_req(0, 1'b0, lat, ovf_at);
        check("ripple3_lat", 32'(lat), 32'd5);
        check("ripple3_count", 32'(count_out), 32'h1000);
        check("ripple3_no_ovf", 32'(ovf_at), 32'hFFFF_FFFF);

        // Clear from requester 3 leaves rr_ptr at 0
        do_req(3, 1'b1, lat, ovf_at);
        check("clr3_lat", 32'(lat), 32'd2);
        check("clr3_count", 32'(count_out), 32'h0000);

        // All four request at once: round-robin order, 3-cycle spacing
        exp_q   = {32'd0, 32'd1, 32'd2, 32'd3};
        exp_cyc = {2, 5, 8, 11};
        @(negedge clk);
        req    = 4'b1111;
        req_op = 4'b0000;
        for (int c = 1; c <= 20 && exp_q.size() > 0; c++) begin
            @(posedge clk);
            #1;
            if (|ack) begin
                got = onehot_idx(ack);
                check("rr_order", 32'(got), exp_q.pop_front());
                check("rr_cycle", 32'(c), 32'(exp_cyc.pop_front()));
                @(negedge clk);
                if (got >= 0) req[got] = 1'b0;
            end
        end
        req = '0;
        check("rr_all_acked", 32'(exp_q.size()), 32'd0);
        check("rr_count", 32'(count_out), 32'h0004);

        // Full wrap: overflow one cycle before ack
        preload(16'hFFFF);
        do_req(1, 1'b0, lat, ovf_at);
        check("wrap_lat", 32'(lat), 32'd5);
        check("wrap_ovf_cycle", 32'(ovf_at), 32'd4);
        check("wrap_count", 32'(count_out), 32'h0000);
        #1;
        check("wrap_ovf_low_after", 32'(overflow), 32'h0);

        // Clear from requester 2
        preload(16'h0005);
        check("pre_clr_count", 32'(count_out), 32'h0005);
        do_req(2, 1'b1, lat, ovf_at);
        check("clr2_lat", 32'(lat), 32'd2);
        check("clr2_count", 32'(count_out), 32'h0000);

        // Reset during the ripple of a 0x00FF increment
        preload(16'h00FF);
        ack_seen = 1'b0;
        @(negedge clk);
        req[0]    = 1'b1;
        req_op[0] = 1'b0;
        watch_ack(2);
        check("abort_mid_state", 32'(dbg_state), 32'(ST_INC));
        check("abort_mid_count", 32'(count_out), 32'h00F0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_rst_sub_cmd", 32'(sub_cmd), 32'h00);
        check("abort_rst_busy", 32'(busy), 32'h1);
        req = '0;
        watch_ack(2);
        @(negedge clk);
        rst_n = 1'b1;
        watch_ack(2);
        check("abort_no_ack", 32'(ack_seen), 32'h0);
        check("abort_count", 32'(count_out), 32'h0000);
        check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        check("abort_busy", 32'(busy), 32'h0);

        // Final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
